// File: rtl/serializer_pkg.sv
// Shared types and defaults for the PISO serializer.
package serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE,
    SHIFT
  } ser_state_t;

endpackage

// File: rtl/shift_counter.sv
// Loadable down-counter tracking how many bits of the current word remain.
module shift_counter
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CntW  = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            dec,
  output logic [CntW-1:0] cnt,
  output logic            last
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CntW'(WIDTH);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CntW'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a word on a valid/ready load
// handshake and shifts it out MSB-first on each enabled clock.
module piso_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_dec;
  logic [CntW-1:0]  cnt;
  logic             last;

  shift_counter #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_shift_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .cnt     (cnt),
    .last    (last)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // enable is deliberately ignored on the load edge
        if (load_valid) begin
          state_d  = SHIFT;
          shreg_d  = load_data;
          cnt_load = 1'b1;
        end
      end
      SHIFT: begin
        if (enable) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_dec = 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  // While a word is in flight the remaining-bit count must stay within 1..WIDTH.
  always @(posedge clk) begin
    if (reset_n && (state_q == SHIFT)) begin
      assert ((cnt != '0) && (cnt <= CntW'(WIDTH)));
    end
  end

  assign load_ready = (state_q == IDLE);
  assign sdo_valid  = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign sdo        = shreg_q[WIDTH-1];
  assign done       = done_q;

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out MSB-first, one bit per enabled clock. It is the send end of the serial bit path: the downstream side holds one enabled D flip-flop that samples `sdo` whenever `enable` is high. This block is the producer that feeds it. Shifting is gated by the same `enable` strobe, so bits advance in lockstep with the receiving flop.

## Interface
- WIDTH, 8, word length in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  shift strobe; high = current bit consumed this edge, low = hold
- load_valid  input  1  load_data valid this cycle
- load_data  input  WIDTH  word to transmit
- load_ready  output  1  block can accept a word (combinational: state == IDLE)
- sdo  output  1  serial data out, registered (MSB of shift register)
- sdo_valid  output  1  sdo holds a live bit (state == SHIFT)
- busy  output  1  transmission in progress (same as sdo_valid)
- done  output  1  one-cycle registered pulse after the last bit is consumed

## Operation
- States:
  - IDLE: load_ready=1, sdo_valid=0.
  - SHIFT: load_ready=0, sdo_valid=1.
- IDLE -> SHIFT on an edge where load_valid && load_ready:
  - shreg <= load_data
  - cnt <= WIDTH
  - `enable` is ignored on the load edge.
- In SHIFT, on an edge with enable=1:
  - shreg <= {shreg[WIDTH-2:0], 1'b0}
  - cnt <= cnt-1
- In SHIFT, on an edge with enable=1 and cnt==1: the last bit is consumed. Next state is IDLE and done <= 1.
- In SHIFT, enable=0: shreg, cnt and state hold, and sdo is stable.
- load_valid in SHIFT: ignored. The word is not captured and not queued.
- done is 0 on every edge except the edge that consumes the last bit.
- Zero fill: after WIDTH shifts, shreg is all-zero, so sdo=0 in IDLE.
- cnt width: $clog2(WIDTH+1). cnt never wraps below 0 and never exceeds WIDTH.
- Reset (reset_n low, any time, including mid-word):
  - state=IDLE, shreg=0, cnt=0, sdo=0, sdo_valid=0, busy=0, done=0, load_ready=1.
  - The partial word is discarded and no done pulse is produced.
- Load attempts while reset_n is low are ignored.

## Timing
- Load accepted at edge k: sdo = load_data[WIDTH-1] and sdo_valid=1 from just after edge k.
- With enable held high, bit i is driven for exactly one cycle. load_data[0] is driven in the cycle before edge k+WIDTH.
- Edge k+WIDTH: state returns to IDLE and done=1 for that one cycle. load_ready=1 in the same cycle.
- A new word can be accepted at edge k+WIDTH+1. Throughput is 1 word per WIDTH+1 cycles at full enable.
- Each enable=0 cycle in SHIFT stretches the transfer by exactly one cycle.
- Reset release: the block is ready immediately. The first load can be accepted at the first rising edge with reset_n high.

## Structure
- Package serializer_pkg holds:
  - typedef enum logic {IDLE, SHIFT} ser_state_t
  - the default WIDTH localparam
- One sub-module, shift_counter: loadable down-counter with enable and async active-low clear. It outputs cnt and last (cnt==1).
- The state register, shift register and done flop stay in piso_serializer.

## Test plan
- Basic transfer: reset, then load 8'hA5 with enable held high.
  - sdo = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - done pulses exactly once, one cycle wide.
  - sdo=0 and load_ready=1 afterwards.
- Enable stalls: load 8'hC3, toggle enable 1,0,1,0...
  - Each bit holds through its enable=0 cycles.
  - Sequence is 1,1,0,0,0,0,1,1.
  - done occurs after the 8th enabled edge, 16 cycles after load.
- Load while busy: load 8'hF0, then present load_valid with 8'h0F at bit 3.
  - load_ready=0 in that cycle.
  - The output stream is unaltered F0.
  - The second word is not transmitted.
- Reset mid-word: load 8'hFF, pull reset_n low after 4 bits.
  - All outputs go to reset values immediately (asynchronously).
  - No done pulse.
  - The next load of 8'h81 transmits cleanly.
- Back-to-back: load 8'h01, then present 8'h80 with load_valid held high.
  - The second load is accepted on the edge after done.
  - Output shows a one-cycle sdo_valid=0 gap between the words.
- WIDTH=2 parameter check: load 2'b10 -> sdo = 1 then 0, with done 2 enabled edges after the load.
